uart_fifo_controller: RTL

//  Wishbone-slave UART with parametrised TX and RX FIFOs, sticky error flags and a maskable interrupt.

---
 rtl/uart_pkg.sv | 19 +
 rtl/async_receiver.sv | 72 +++++++
 rtl/async_transmitter.sv | 47 ++++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_fifo_controller.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Register offsets, STATUS bit positions and TX FSM
// encodings shared by the FIFO UART controller.
package uart_pkg;
  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_IER    = 8'h01;
  localparam logic [7:0] REG_STATUS = 8'h05;
  localparam logic [7:0] REG_LEVEL  = 8'h06;

  localparam int ST_RX_NE   = 0;
  localparam int ST_RX_OVF  = 1;
  localparam int ST_TX_OVF  = 2;
  localparam int ST_TX_NF   = 5;
  localparam int ST_TX_IDLE = 6;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE   = 2'd0;
  localparam tx_state_t TX_LAUNCH = 2'd1;
  localparam tx_state_t TX_WAIT   = 2'd2;
endpackage

// File: rtl/async_receiver.sv
// 8N1 serial receiver, no reset. Ports: rxd in, clear in,
// data/ready out; ready is sticky until clear.
module async_receiver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rxd,
  input  logic       rxd_clear,
  output logic [7:0] rxd_data,
  output logic       rxd_data_ready
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;

  // Synchroniser stores the inverted line so a
  // zero power-up state reads as an idle-high line.
  logic rxn1_q, rxn2_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    sh_q, sh_d, data_q, data_d;
  logic          rdy_q, rdy_d;

  assign rxd_data       = data_q;
  assign rxd_data_ready = rdy_q;

  always_comb begin
    st_d   = st_q;
    baud_d = baud_q;
    nbit_d = nbit_q;
    sh_d   = sh_q;
    data_d = data_q;
    rdy_d  = rdy_q & ~rxd_clear;
    unique case (st_q)
      2'd0: if (rxn2_q) begin
        st_d   = 2'd1;
        baud_d = CW'(DIV / 2 - 1);
      end
      2'd1: if (baud_q == '0) begin
        st_d   = rxn2_q ? 2'd2 : 2'd0;
        baud_d = CW'(DIV - 1);
        nbit_d = 3'd0;
      end else baud_d = baud_q - CW'(1);
      2'd2: if (baud_q == '0) begin
        sh_d   = {~rxn2_q, sh_q[7:1]};
        baud_d = CW'(DIV - 1);
        nbit_d = nbit_q + 3'd1;
        if (nbit_q == 3'd7) st_d = 2'd3;
      end else baud_d = baud_q - CW'(1);
      2'd3: if (baud_q == '0) begin
        st_d = 2'd0;
        if (!rxn2_q) begin
          data_d = sh_q;
          rdy_d  = 1'b1;
        end
      end else baud_d = baud_q - CW'(1);
      default: st_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    rxn1_q <= ~rxd;
    rxn2_q <= rxn1_q;
    st_q   <= st_d;
    baud_q <= baud_d;
    nbit_q <= nbit_d;
    sh_q   <= sh_d;
    data_q <= data_d;
    rdy_q  <= rdy_d;
  end
endmodule

// File: rtl/async_transmitter.sv
// 8N1 serial transmitter, no reset: an in-flight
// frame always completes. Ports: start/data in, txd/busy out.
module async_transmitter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       txd_start,
  input  logic [7:0] txd_data,
  output logic       txd,
  output logic       txd_busy
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV) + 1;

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bits_q, bits_d;
  logic [9:0]    sh_q, sh_d;

  assign txd_busy = (bits_q != 4'd0);
  assign txd      = txd_busy ? sh_q[0] : 1'b1;

  always_comb begin
    baud_d = baud_q;
    bits_d = bits_q;
    sh_d   = sh_q;
    if (!txd_busy) begin
      if (txd_start) begin
        sh_d   = {1'b1, txd_data, 1'b0};
        bits_d = 4'd10;
        baud_d = CW'(DIV - 1);
      end
    end else if (baud_q == '0) begin
      baud_d = CW'(DIV - 1);
      sh_d   = {1'b1, sh_q[9:1]};
      bits_d = bits_q - 4'd1;
    end else begin
      baud_d = baud_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    baud_q <= baud_d;
    bits_q <= bits_d;
    sh_q   <= sh_d;
  end
endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, first-word fall-through head.
// Ports: push/pop, din/dout, full/empty, count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the slot first, so push
  // into a full FIFO succeeds when popping.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push)
          - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/uart_fifo_controller.sv
// Wishbone UART with TX/RX FIFOs, sticky overflow flags, IRQ.
// Ports: wb_* slave bus, uart_txd_o/uart_rxd_i line, irq_o.
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    uart_txd_o,
  input  logic                    uart_rxd_i,
  output logic                    irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic ack_q, ack_d, irq_q, irq_d;
  logic rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic rxd_clear_q, rxd_clear_d;
  logic [2:0] ier_q, ier_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, rdata;
  logic [7:0] txd_data_q, txd_data_d, status;
  tx_state_t state_q, state_d;

  logic [7:0] adr, tx_dout, rx_dout, rxd_data;
  logic accept, wr, rd, status_rd;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic txd_start, txd_busy, rxd_ready;
  logic unused_bits;

  assign unused_bits = ^{wb_cyc_i,
    wb_adr_i[ADDR_WIDTH-1:8], wb_dat_i[DATA_WIDTH-1:8]};

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign irq_o     = irq_q;
  assign txd_start = (state_q == TX_LAUNCH);

  always_comb begin
    adr       = wb_adr_i[7:0];
    accept    = wb_stb_i & ~ack_q;
    wr        = accept & wb_we_i;
    rd        = accept & ~wb_we_i;
    ack_d     = accept;
    status_rd = rd & (adr == REG_STATUS);

    state_d    = state_q;
    txd_data_d = txd_data_q;
    tx_pop     = 1'b0;
    unique case (state_q)
      TX_IDLE: if (!tx_empty && !txd_busy) begin
        tx_pop     = 1'b1;
        txd_data_d = tx_dout;
        state_d    = TX_LAUNCH;
      end
      TX_LAUNCH: state_d = TX_WAIT;
      TX_WAIT: if (!txd_busy) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    tx_push = wr & (adr == REG_DATA) & wb_sel_i[0];
    rx_pop  = rd & (adr == REG_DATA) & ~rx_empty;
    // Holding off while clear is in flight avoids
    // pushing the same byte twice.
    rx_push     = rxd_ready & ~rxd_clear_q;
    rxd_clear_d = rx_push;

    // A fresh overflow beats the STATUS read clear.
    tx_ovf_d = (tx_ovf_q & ~status_rd)
             | (tx_push & tx_full & ~tx_pop);
    rx_ovf_d = (rx_ovf_q & ~status_rd)
             | (rx_push & rx_full & ~rx_pop);

    ier_d = ier_q;
    if (wr && adr == REG_IER && wb_sel_i[0])
      ier_d = wb_dat_i[2:0];

    status = '0;
    status[ST_RX_NE]   = ~rx_empty;
    status[ST_RX_OVF]  = rx_ovf_q;
    status[ST_TX_OVF]  = tx_ovf_q;
    status[ST_TX_NF]   = ~tx_full;
    status[ST_TX_IDLE] = tx_empty & ~txd_busy
                       & (state_q == TX_IDLE);

    rdata = '0;
    unique case (1'b1)
      adr == REG_DATA:
        for (int i = 0; i < DATA_WIDTH / 8; i++)
          if (wb_sel_i[i] && !rx_empty)
            rdata[i*8 +: 8] = rx_dout;
      adr == REG_IER:    rdata[2:0] = ier_q;
      adr == REG_STATUS: rdata[7:0] = status;
      adr == REG_LEVEL: begin
        rdata[7:0]  = 8'(rx_count);
        rdata[15:8] = 8'(tx_count);
      end
      default: ;
    endcase
    dat_d = rd ? rdata : dat_q;

    irq_d = |(ier_q & {rx_ovf_q | tx_ovf_q,
                       tx_empty, ~rx_empty});
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      irq_q       <= 1'b0;
      ier_q       <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rxd_clear_q <= 1'b0;
      state_q     <= TX_IDLE;
      txd_data_q  <= '0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      irq_q       <= irq_d;
      ier_q       <= ier_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      rxd_clear_q <= rxd_clear_d;
      state_q     <= state_d;
      txd_data_q  <= txd_data_d;
    end
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_i(tx_push), .pop_i(tx_pop),
    .din_i(wb_dat_i[7:0]), .dout_o(tx_dout),
    .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i),
    .push_i(rx_push), .pop_i(rx_pop),
    .din_i(rxd_data), .dout_o(rx_dout),
    .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_count)
  );

  async_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
    .clk(clk_i), .txd_start(txd_start),
    .txd_data(txd_data_q), .txd(uart_txd_o),
    .txd_busy(txd_busy)
  );

  async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(clk_i), .rxd(uart_rxd_i),
    .rxd_clear(rxd_clear_q), .rxd_data(rxd_data),
    .rxd_data_ready(rxd_ready)
  );
endmodule
